song_reader: RTL

Sequencer that walks one song stored in `song_rom` and drives the note player. It addresses the ROM, decodes each `{note, duration}` entry and hands the note to the player over a valid/ready handshake. It then times the note's duration in beats before fetching the next entry. It sits between the top-level play/song-select controls and the note player, and is the only master of the ROM address bus.

---
 rtl/song_reader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/song_reader.sv
// song_reader: walks one song in song_rom and hands each {note, duration}
// entry to the note player over a valid/ready handshake, then times the
// note in beats before fetching the next entry.
// Optional feature macro: SONG_READER_LOOP_EN (when defined, the end of a
// song wraps back to entry 0 of the same song while play stays high).
module song_reader #(
    parameter int SONG_BITS  = 2,
    parameter int ENTRY_BITS = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic [SONG_BITS-1:0]            song,
    input  logic                            beat,
    output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
    input  logic [15:0]                     rom_dout,
    output logic [5:0]                      note,
    output logic [5:0]                      duration,
    output logic                            note_valid,
    input  logic                            note_ready,
    output logic                            playing,
    output logic                            song_done
);

    localparam int ADDR_BITS = SONG_BITS + ENTRY_BITS;
    localparam logic [ENTRY_BITS-1:0] IDX_ZERO = {ENTRY_BITS{1'b0}};
    localparam logic [ENTRY_BITS-1:0] IDX_LAST = {ENTRY_BITS{1'b1}};
    localparam logic [ENTRY_BITS-1:0] IDX_ONE  = {{(ENTRY_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CHECK   = 3'd2,
        S_HANDOFF = 3'd3,
        S_PLAY    = 3'd4,
        S_END     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [ENTRY_BITS-1:0]  idx_q, idx_d;
    logic [SONG_BITS-1:0]   song_reg_q, song_reg_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   rom_addr_q, rom_addr_d;
    logic [5:0]             note_q, note_d;
    logic [5:0]             duration_q, duration_d;
    logic                   note_valid_q, note_valid_d;
    logic                   playing_q, playing_d;
    logic                   song_done_q, song_done_d;

    logic [ENTRY_BITS-1:0]  idx_next_s;
    logic [5:0]             entry_dur_s;
    logic [5:0]             entry_note_s;
    logic                   unused_rom_bits_s;

    assign idx_next_s        = idx_q + IDX_ONE;
    assign entry_dur_s       = rom_dout[5:0];
    assign entry_note_s      = rom_dout[11:6];
    assign unused_rom_bits_s = ^rom_dout[15:12];

    // Next-state and next-output logic; outputs are derived from the next state
    // so that they come straight out of flops.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        song_reg_d = song_reg_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        note_d     = note_q;
        duration_d = duration_q;

        case (state_q)
            S_IDLE: begin
                if (play) begin
                    song_reg_d = song;
                    idx_d      = IDX_ZERO;
                    rom_addr_d = {song, IDX_ZERO};
                    state_d    = S_FETCH;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_FETCH: begin
                // Synchronous ROM: data for rom_addr appears one cycle later.
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (entry_dur_s == 6'd0) begin
                    // Zero duration marks the end of the song.
                    state_d = S_END;
                end else begin
                    note_d     = entry_note_s;
                    duration_d = entry_dur_s;
                    cnt_d      = entry_dur_s;
                    state_d    = S_HANDOFF;
                end
            end
            S_HANDOFF: begin
                // The handshake completes even while paused.
                if (note_ready) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_HANDOFF;
                end
            end
            S_PLAY: begin
                if (play && beat) begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = S_END;
                        end else begin
                            idx_d      = idx_next_s;
                            rom_addr_d = {song_reg_q, idx_next_s};
                            state_d    = S_FETCH;
                        end
                    end else begin
                        state_d = S_PLAY;
                    end
                end else begin
                    // Paused or no beat this cycle: counter holds.
                    state_d = S_PLAY;
                end
            end
            S_END: begin
                idx_d = IDX_ZERO;
`ifdef SONG_READER_LOOP_EN
                if (play) begin
                    rom_addr_d = {song_reg_q, IDX_ZERO};
                    state_d    = S_FETCH;
                end else begin
                    state_d    = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        note_valid_d = (state_d == S_HANDOFF);
        playing_d    = (state_d != S_IDLE);
        song_done_d  = (state_d == S_END);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= IDX_ZERO;
            song_reg_q   <= {SONG_BITS{1'b0}};
            cnt_q        <= 6'd0;
            rom_addr_q   <= {ADDR_BITS{1'b0}};
            note_q       <= 6'd0;
            duration_q   <= 6'd0;
            note_valid_q <= 1'b0;
            playing_q    <= 1'b0;
            song_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            song_reg_q   <= song_reg_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            note_q       <= note_d;
            duration_q   <= duration_d;
            note_valid_q <= note_valid_d;
            playing_q    <= playing_d;
            song_done_q  <= song_done_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note       = note_q;
    assign duration   = duration_q;
    assign note_valid = note_valid_q;
    assign playing    = playing_q;
    assign song_done  = song_done_q;

endmodule
